// File: rtl/sdram_rd_arb.sv
// Four-port SDRAM read arbiter: one outstanding read, result broadcast on dout with a one-hot dout_ok pulse.
// Define SDRAM_RD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (req[0] highest).
module sdram_rd_arb #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [3:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  output logic [DW-1:0] dout,
  output logic [3:0]    dout_ok,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic [DW-1:0] data_read,
  input  logic          autorefresh
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t        r_state;
  logic [1:0]    r_win;
  logic          r_armed;
  logic [1:0]    w_start;
  logic          w_gnt_vld;
  logic [1:0]    w_gnt_idx;
  logic [AW-1:0] w_gnt_addr;
  logic          w_grant;

`ifdef SDRAM_RD_ARB_RR_EN
  // r_ptr holds the index the next search starts from (one past the last winner).
  logic [1:0] r_ptr;
  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif

  always_comb begin
    logic [1:0] w_idx;
    w_idx     = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = w_start + i[1:0];
      if (!w_gnt_vld && req[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  always_comb begin
    w_gnt_addr = '0;
    case (w_gnt_idx)
      2'd0:    w_gnt_addr = addr0;
      2'd1:    w_gnt_addr = addr1;
      2'd2:    w_gnt_addr = addr2;
      default: w_gnt_addr = addr3;
    endcase
  end

  // r_armed delays the first grant after reset release by one edge.
  assign w_grant = w_gnt_vld && r_armed && !downloading && !autorefresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_win      <= '0;
      r_armed    <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      dout       <= '0;
      dout_ok    <= '0;
`ifdef SDRAM_RD_ARB_RR_EN
      r_ptr      <= '0;
`endif
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            sdram_req  <= 1'b1;
            sdram_addr <= w_gnt_addr;
            r_win      <= w_gnt_idx;
`ifdef SDRAM_RD_ARB_RR_EN
            r_ptr      <= w_gnt_idx + 2'd1;
`endif
            r_state    <= ST_WAIT;
          end else begin
            sdram_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (sdram_ack) begin
            dout      <= data_read;
            sdram_req <= 1'b0;
            dout_ok   <= 4'b0001 << r_win;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          dout_ok <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rd_arb.sv
// Self-checking bench for sdram_rd_arb: directed steps with random data/addresses against a transaction-level model.
module tb_sdram_rd_arb;
  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          downloading;
  logic [3:0]    req;
  logic [AW-1:0] am [4];
  logic [DW-1:0] dout;
  logic [3:0]    dout_ok;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic [DW-1:0] data_read;
  logic          autorefresh;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int          model_last;
  logic [DW-1:0] model_dout;

  always #5 clk = ~clk;

  sdram_rd_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .req(req),
    .addr0(am[0]), .addr1(am[1]), .addr2(am[2]), .addr3(am[3]),
    .dout(dout), .dout_ok(dout_ok), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_read(data_read), .autorefresh(autorefresh)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Winner from the arbitration rule: lowest index, or first set index after the last winner.
  function automatic int pick(input logic [3:0] r, input int last);
`ifdef SDRAM_RD_ARB_RR_EN
    for (int off = 1; off <= 4; off++) begin
      int j;
      j = (last + off) % 4;
      if (r[j]) return j;
    end
`else
    for (int j = 0; j < 4; j++)
      if (r[j]) return j;
`endif
    return -1;
  endfunction

  task automatic randomize_addrs();
    for (int i = 0; i < 4; i++) am[i] = AW'($urandom);
  endtask

  // Called while observing the first WAIT cycle; returns while observing the IDLE cycle after DONE.
  task automatic serve(input int unsigned dly, input int win, input logic [DW-1:0] d,
                       input logic [3:0] req_during, input logic rf_during);
    logic [AW-1:0] a;
    a = am[win];
    chk("grant_req", 64'(sdram_req), 64'd1);
    chk("grant_addr", 64'(sdram_addr), 64'(a));
    req = req_during;
    autorefresh = rf_during;
    repeat (dly) begin
      tick();
      chk("wait_req", 64'(sdram_req), 64'd1);
      chk("wait_addr", 64'(sdram_addr), 64'(a));
      chk("wait_ok", 64'(dout_ok), 64'd0);
      chk("wait_dout", 64'(dout), 64'(model_dout));
    end
    sdram_ack = 1'b1;
    data_read = d;
    tick();
    sdram_ack = 1'b0;
    data_read = DW'($urandom);
    model_dout = d;
    model_last = win;
    chk("done_dout", 64'(dout), 64'(d));
    chk("done_ok", 64'(dout_ok), 64'(4'b0001 << win));
    chk("done_req", 64'(sdram_req), 64'd0);
    tick();
    chk("idle_ok", 64'(dout_ok), 64'd0);
    chk("idle_dout", 64'(dout), 64'(d));
    chk("idle_req", 64'(sdram_req), 64'd0);
  endtask

  initial begin
    logic [3:0] r;
    int w;
    rst_n = 1'b0; downloading = 1'b0; req = '0; sdram_ack = 1'b0;
    data_read = '0; autorefresh = 1'b0;
    randomize_addrs();
    model_last = 3;
    model_dout = '0;
    tick(); tick();
    chk("rst_req", 64'(sdram_req), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_ok", 64'(dout_ok), 64'd0);

    // Release with a pending request: no grant on the first edge, grant on the second.
    rst_n = 1'b1;
    req = 4'b0001;
    tick();
    chk("rel_edge1_req", 64'(sdram_req), 64'd0);
    tick();
    serve($urandom_range(0, 4), 0, DW'($urandom), 4'b0001, 1'b0);

    // Single read from requester 2, ack five cycles after sdram_req.
    req = 4'b0100;
    am[2] = 22'h012345;
    tick();
    serve(5, 2, 32'hDEADBEEF, 4'b0000, 1'b0);

    // Ack outside WAIT is ignored.
    sdram_ack = 1'b1; data_read = DW'($urandom);
    tick();
    sdram_ack = 1'b0;
    tick();
    chk("stray_ok", 64'(dout_ok), 64'd0);
    chk("stray_dout", 64'(dout), 64'(model_dout));
    chk("stray_req", 64'(sdram_req), 64'd0);

    // Continuous full contention.
    req = 4'b1111;
    randomize_addrs();
    for (int n = 0; n < 6; n++) begin
      tick();
      w = pick(req, model_last);
      serve($urandom_range(0, 3), w, DW'($urandom), 4'b1111, 1'b0);
    end

    // Download blocking.
    req = 4'b0001; downloading = 1'b1;
    repeat (3) begin
      tick();
      chk("dl_block_req", 64'(sdram_req), 64'd0);
    end
    downloading = 1'b0;
    tick();
    serve($urandom_range(0, 3), pick(4'b0001, model_last), DW'($urandom), 4'b0000, 1'b0);

    // Refresh blocking.
    req = 4'b0010; autorefresh = 1'b1;
    repeat (3) begin
      tick();
      chk("rf_block_req", 64'(sdram_req), 64'd0);
    end
    autorefresh = 1'b0;
    tick();
    serve($urandom_range(0, 3), pick(4'b0010, model_last), DW'($urandom), 4'b0010, 1'b0);

    // Random mix: requester drops, refresh rising mid-WAIT.
    for (int n = 0; n < 16; n++) begin
      logic rf;
      r = 4'($urandom_range(1, 15));
      randomize_addrs();
      req = r;
      tick();
      w = pick(r, model_last);
      rf = 1'($urandom);
      serve($urandom_range(0, 4), w, DW'($urandom), ($urandom_range(0, 1) == 0) ? 4'b0000 : r, rf);
      if (rf) begin
        req = r;
        tick();
        chk("rf_hold_req", 64'(sdram_req), 64'd0);
        autorefresh = 1'b0;
        tick();
        w = pick(r, model_last);
        serve(0, w, DW'($urandom), 4'b0000, 1'b0);
      end
    end

    // Reset during WAIT clears outputs immediately; a later stray ack does nothing.
    req = 4'b1111;
    tick();
    chk("pre_rst_req", 64'(sdram_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(sdram_req), 64'd0);
    chk("mid_rst_ok", 64'(dout_ok), 64'd0);
    chk("mid_rst_dout", 64'(dout), 64'd0);
    model_dout = '0;
    model_last = 3;
    req = '0;
    tick();
    rst_n = 1'b1;
    sdram_ack = 1'b1; data_read = DW'($urandom);
    tick(); tick();
    sdram_ack = 1'b0;
    tick();
    chk("post_rst_ok", 64'(dout_ok), 64'd0);
    chk("post_rst_dout", 64'(dout), 64'd0);
    chk("post_rst_req", 64'(sdram_req), 64'd0);
    req = 4'b1111;
    tick();
    serve(1, pick(4'b1111, model_last), DW'($urandom), 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
